alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Drives the ALU: accepts one RV32I integer instruction per transaction over a valid/ready handshake and decodes it into an `ALU_*` op code plus operands. Reads the register file, drives the ALU for its one registered cycle of latency, then presents the result on a write-back handshake. Sits between fetch and the register file / ALU pair of the single-issue core.

Parameters:
XLEN, 32, datapath width; must match the ALU (32).
REG_AW, 5, register-file address width.

Ports:
clk  in  1  clock; shared with ALU and regfile.
rst  in  1  synchronous active-high reset; must be the same net as the ALU rst.
instr_valid  in  1  instruction word available.
instr  in  32  RV32I instruction word.
instr_ready  out  1  block can accept; high only in IDLE.
rf_raddr1  out  REG_AW  rs1 index (instr[19:15]).
rf_raddr2  out  REG_AW  rs2 index (instr[24:20]).
rf_rdata1  in  XLEN  rs1 data; combinational (async) read, same cycle.
rf_rdata2  in  XLEN  rs2 data; combinational (async) read, same cycle.
alu_op  out  4  `ALU_*` code to ALU op.
alu_a  out  XLEN  to ALU in_a.
alu_b  out  XLEN  to ALU in_b.
alu_result  in  XLEN  ALU out_s.
wb_valid  out  1  result available.
wb_rd  out  REG_AW  destination register.
wb_data  out  XLEN  result (alu_result passed through while in WB).
wb_ready  in  1  write-back consumer accepts.
illegal  out  1  one-cycle pulse on undecodable instruction.
cnt_retired  out  32  see Optional Feature.
cnt_illegal  out  32  see Optional Feature.

Behaviour:
- States: IDLE, READ, EXEC, WB, ERR.
- Registered outputs: alu_op, alu_a, alu_b, wb_rd and illegal are registers. instr_ready, wb_valid and wb_data are decoded from state.
- Reset values: state=IDLE; instr register, alu_op, alu_a, alu_b and wb_rd all 0; illegal=0; counters=0. Hence instr_ready=1 and wb_valid=0 out of reset.
- IDLE -> READ: on instr_valid & instr_ready. The instruction is captured in an internal register.
- READ: rf_raddr1/rf_raddr2 are driven from the captured instruction.
  - If legal, load alu_op/alu_a/alu_b and wb_rd=instr[11:7], then go to EXEC.
  - If illegal, go to ERR; operand registers are unchanged.
- EXEC: operands held stable; the ALU registers its result at the end of this cycle. Go to WB.
- WB: wb_valid=1 and wb_data=alu_result.
  - ALU inputs stay held, so alu_result is stable for as long as WB lasts.
  - On wb_ready, go to IDLE.
  - Otherwise hold; wb_rd and wb_data must not change.
- ERR: illegal=1 for exactly this cycle, no write-back, then IDLE.
- Latency: accept edge to first wb_valid cycle is 3 cycles. Throughput is one instruction per 4 cycles with wb_ready held high.
- Decode, OP (0110011), alu_a=rs1, alu_b=rs2:
  - funct7=0000000: funct3 selects ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7=0100000: funct3=000 gives SUB, funct3=101 gives SRA.
  - Any other funct7/funct3 combination is illegal.
- Decode, OP-IMM (0010011), alu_a=rs1, alu_b=sign-extended instr[31:20]:
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI.
  - SLTIU compares against the sign-extended immediate as unsigned.
  - SLLI requires funct7=0000000.
  - SRLI/SRAI use funct7=0000000 or 0100000 respectively; alu_b is zero-extended shamt[4:0].
  - Any other shift funct7 is illegal.
- Decode, LUI (0110111): alu_op=`ALU_PASS_B`, alu_a=0, alu_b={instr[31:12],12'b0}.
- All other opcodes are illegal.
- rd=x0: write-back is still issued with wb_rd=0; the regfile discards it.
- instr_valid outside IDLE is ignored; instr_ready=0 there.
- Reset mid-operation (any state): the in-flight instruction is dropped and there is no wb_valid/illegal pulse. The next cycle is IDLE, and the ALU clears out_s in the same edge.

Optional Feature:
- Macro: ALU_ISSUE_PERF_CNT_EN.
- With the macro defined:
  - cnt_retired increments on every WB cycle with wb_ready=1.
  - cnt_illegal increments on every ERR cycle.
  - Both are 32-bit, wrap 0xFFFFFFFF->0, and are cleared by rst.
- Without it: both ports are tied to 0 and no counter flops are built.

Decomposition:
- Shared defines file (existing risc-v defines): `ALU_*` op codes, plus new opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, funct3 codes and funct7 values F7_BASE/F7_ALT.
- State encoding stays local.
- One sub-module, alu_op_decode: purely combinational; takes instr, rf_rdata1 and rf_rdata2 and produces op, a, b and illegal. The FSM top registers its outputs.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with x1=5, x2=7, wb_ready=1 -> alu_op=`ALU_ADD`; wb_valid 3 cycles after accept with wb_rd=3, wb_data=12; instr_ready back high next cycle.
- SRAI x5,x1,4 (0x4040D293), x1=0x80000000 -> wb_data=0xF8000000. SRLI (0x0040D293) -> 0x08000000.
- SLTI x4,x1,-1 (0xFFF0A213) and SLTIU x4,x1,-1 (0xFFF0B213), x1=0 -> wb_data 0 and 1 respectively.
- LUI x7,0x12345 (0x123453B7) with wb_ready low 4 cycles -> wb_valid, wb_rd=7 and wb_data=0x12345000 held stable; instr_ready=0 throughout; completes on wb_ready.
- instr=0x0000007F, then SUB with funct7=0x21 (0x422081B3) -> each gives a single-cycle illegal pulse, no wb_valid; with the macro, cnt_illegal=2 and cnt_retired=0.
- rst asserted during EXEC of an ADD -> next cycle state IDLE, instr_ready=1, wb_valid never asserted.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared RV32I opcode/funct constants and ALU op codes for the ALU issue path
package alu_issue_ctrl_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    // funct3 -> op for the funct7=BASE flavour shared by OP and OP-IMM
    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            F3_ADD_SUB: return ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SR:      return ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I OP/OP-IMM/LUI decode into ALU op and operands
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    output logic [3:0]      op,
    output logic [XLEN-1:0] a,
    output logic [XLEN-1:0] b,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] shamt;
    logic            dec_unused;

    assign opcode     = instr[6:0];
    assign f3         = instr[14:12];
    assign f7         = instr[31:25];
    assign imm_i      = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign shamt      = {{(XLEN-5){1'b0}}, instr[24:20]};
    assign dec_unused = ^instr[19:7];

    always_comb begin
        op      = ALU_ADD;
        a       = rf_rdata1;
        b       = rf_rdata2;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (f7 == F7_BASE)
                    op = base_op(f3);
                else if (f7 == F7_ALT && f3 == F3_ADD_SUB)
                    op = ALU_SUB;
                else if (f7 == F7_ALT && f3 == F3_SR)
                    op = ALU_SRA;
                else
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                b = imm_i;
                case (f3)
                    F3_SLL: begin
                        op      = ALU_SLL;
                        b       = shamt;
                        illegal = (f7 != F7_BASE);
                    end
                    F3_SR: begin
                        b = shamt;
                        if (f7 == F7_BASE)
                            op = ALU_SRL;
                        else if (f7 == F7_ALT)
                            op = ALU_SRA;
                        else
                            illegal = 1'b1;
                    end
                    default: op = base_op(f3);
                endcase
            end
            OPC_LUI: begin
                op = ALU_PASS_B;
                a  = '0;
                b  = XLEN'({instr[31:12], 12'b0});
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue ALU sequencer: accept, read regfile, execute, write back
// Optional retire/illegal counters under `ALU_ISSUE_PERF_CNT_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata1,
    input  logic [XLEN-1:0]   rf_rdata2,
    output logic [3:0]        alu_op,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    input  logic [XLEN-1:0]   alu_result,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    input  logic              wb_ready,
    output logic              illegal,
    output logic [31:0]       cnt_retired,
    output logic [31:0]       cnt_illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     instr_q;
    logic [3:0]      dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic            dec_illegal;

    assign rf_raddr1 = instr_q[15 +: REG_AW];
    assign rf_raddr2 = instr_q[20 +: REG_AW];

    alu_op_decode #(.XLEN(XLEN)) u_dec (
        .instr     (instr_q),
        .rf_rdata1 (rf_rdata1),
        .rf_rdata2 (rf_rdata2),
        .op        (dec_op),
        .a         (dec_a),
        .b         (dec_b),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (instr_valid) state_nxt = S_READ;
            S_READ: state_nxt = dec_illegal ? S_ERR : S_EXEC;
            S_EXEC: state_nxt = S_WB;
            S_WB:   if (wb_ready) state_nxt = S_IDLE;
            S_ERR:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operands stay held through EXEC and WB so the ALU's registered result is stable in WB
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            instr_q <= '0;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            wb_rd   <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nxt;
            illegal <= (state == S_READ) && dec_illegal;
            if (state == S_IDLE && instr_valid)
                instr_q <= instr;
            if (state == S_READ && !dec_illegal) begin
                alu_op <= dec_op;
                alu_a  <= dec_a;
                alu_b  <= dec_b;
                wb_rd  <= instr_q[7 +: REG_AW];
            end
        end
    end

    assign instr_ready = (state == S_IDLE);
    assign wb_valid    = (state == S_WB);
    assign wb_data     = wb_valid ? alu_result : '0;

`ifdef ALU_ISSUE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_retired <= '0;
            cnt_illegal <= '0;
        end else begin
            if (state == S_WB && wb_ready)
                cnt_retired <= cnt_retired + 32'd1;
            if (state == S_ERR)
                cnt_illegal <= cnt_illegal + 32'd1;
        end
    end
`else
    assign cnt_retired = '0;
    assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with regfile and ALU models
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic [3:0]  alu_op;
    logic [31:0] alu_a, alu_b, alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        illegal;
    logic [31:0] cnt_retired, cnt_illegal;

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(32), .REG_AW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .rf_raddr1   (rf_raddr1),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .illegal     (illegal),
        .cnt_retired (cnt_retired),
        .cnt_illegal (cnt_illegal)
    );

    assign rf_rdata1 = regs[rf_raddr1];
    assign rf_rdata2 = regs[rf_raddr2];

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_SLL:    return a << b[4:0];
            ALU_SLT:    return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   return {31'b0, a < b};
            ALU_XOR:    return a ^ b;
            ALU_SRL:    return a >> b[4:0];
            ALU_SRA:    return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            ALU_PASS_B: return b;
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) alu_result <= '0;
        else     alu_result <= alu_f(alu_op, alu_a, alu_b);
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    typedef struct {
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] r1;
        logic [31:0] r2;
        int          stall;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
    } vec_t;

    exp_t sbq[$];
    vec_t tv[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (!rst && ((wb_valid && wb_ready) || illegal)) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("sb_kind_illegal", {31'b0, illegal}, {31'b0, mon_e.ill});
                if (mon_e.ill) begin
                    check("sb_no_wb_on_illegal", {31'b0, wb_valid}, 32'd0);
                end else begin
                    check("sb_wb_rd", {27'b0, wb_rd}, {27'b0, mon_e.rd});
                    check("sb_wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    task automatic add_vec(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                           input int stall, input logic ill, input logic [4:0] rd, input logic [31:0] data);
        vec_t v;
        v.ins = ins; v.r1 = r1; v.r2 = r2; v.stall = stall;
        v.ill = ill; v.rd = rd; v.data = data;
        tv.push_back(v);
    endtask

    task automatic run(input vec_t v, input bit lat);
        int          n;
        logic [4:0]  rd0;
        logic [31:0] d0;
        logic [3:0]  op_seen;
        exp_t        e;
        op_seen = '0;
        regs[1] = v.r1;
        regs[2] = v.r2;
        e.ill = v.ill; e.rd = v.rd; e.data = v.data;
        sbq.push_back(e);
        @(posedge clk); #1;
        wb_ready = (v.stall == 0);
        check("instr_ready_idle", {31'b0, instr_ready}, 32'd1);
        instr = v.ins;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = 32'h0000_0000;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 2) op_seen = alu_op;
        end while (!(wb_valid || illegal) && n < 20);
        if (!(wb_valid || illegal)) check("result_timeout", 32'd0, 32'd1);
        if (lat) begin
            check("add_latency", n, 32'd3);
            check("add_alu_op", {28'b0, op_seen}, {28'b0, ALU_ADD});
        end
        if (v.ill) check("illegal_latency", n, 32'd2);
        if (v.stall > 0) begin
            rd0 = wb_rd;
            d0  = wb_data;
            for (int k = 1; k < v.stall; k++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check("stall_wb_valid", {31'b0, wb_valid}, 32'd1);
                check("stall_wb_rd", {27'b0, wb_rd}, {27'b0, rd0});
                check("stall_wb_data", wb_data, d0);
                check("stall_instr_ready", {31'b0, instr_ready}, 32'd0);
            end
            @(posedge clk); #1;
            wb_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        check("ready_after_done", {31'b0, instr_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   bad;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = 32'h0;
        wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_instr_ready", {31'b0, instr_ready}, 32'd1);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_alu_op", {28'b0, alu_op}, 32'd0);
        check("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        check("rst_cnt_retired", cnt_retired, 32'd0);
        check("rst_cnt_illegal", cnt_illegal, 32'd0);

        add_vec(32'h002081B3, 32'd5,        32'd7,        0, 1'b0, 5'd3, 32'd12);
        add_vec(32'h4040D293, 32'h80000000, 32'd0,        0, 1'b0, 5'd5, 32'hF8000000);
        add_vec(32'h0040D293, 32'h80000000, 32'd0,        0, 1'b0, 5'd5, 32'h08000000);
        add_vec(32'hFFF0A213, 32'd0,        32'd0,        0, 1'b0, 5'd4, 32'd0);
        add_vec(32'hFFF0B213, 32'd0,        32'd0,        0, 1'b0, 5'd4, 32'd1);
        add_vec(32'h123453B7, 32'hAAAA5555, 32'h5555AAAA, 4, 1'b0, 5'd7, 32'h12345000);
        add_vec(32'h0000007F, 32'd0,        32'd0,        0, 1'b1, 5'd0, 32'd0);
        add_vec(32'h422081B3, 32'd5,        32'd7,        0, 1'b1, 5'd0, 32'd0);
        add_vec(32'h402081B3, 32'd5,        32'd7,        0, 1'b0, 5'd3, 32'hFFFFFFFE);
        add_vec(32'h00108013, 32'd9,        32'd0,        0, 1'b0, 5'd0, 32'd10);
        add_vec(32'h002091B3, 32'd1,        32'd4,        0, 1'b0, 5'd3, 32'd16);
        add_vec(32'h0020B1B3, 32'd1,        32'hFFFFFFFF, 0, 1'b0, 5'd3, 32'd1);
        add_vec(32'h0F00E313, 32'h0000000F, 32'd0,        0, 1'b0, 5'd6, 32'h000000FF);
        add_vec(32'h40109293, 32'd3,        32'd0,        0, 1'b1, 5'd0, 32'd0);

        for (int i = 0; i < tv.size(); i++) run(tv[i], i == 0);

        check("sb_drained", sbq.size(), 32'd0);
`ifdef ALU_ISSUE_PERF_CNT_EN
        check("cnt_retired_final", cnt_retired, 32'd11);
        check("cnt_illegal_final", cnt_illegal, 32'd3);
`else
        check("cnt_retired_tied", cnt_retired, 32'd0);
        check("cnt_illegal_tied", cnt_illegal, 32'd0);
`endif

        regs[1] = 32'd5;
        regs[2] = 32'd7;
        @(posedge clk); #1;
        instr = 32'h002081B3;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_instr_ready", {31'b0, instr_ready}, 32'd1);
        check("midrst_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("midrst_cnt_retired", cnt_retired, 32'd0);
        check("midrst_cnt_illegal", cnt_illegal, 32'd0);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (wb_valid || illegal || !instr_ready) bad++;
        end
        check("midrst_quiet", bad, 32'd0);
        check("sb_drained_end", sbq.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
